// File: rtl/timer_dev_pkg.sv
// Shared register offsets, mode codes, FSM state encoding and CTRL layout for timer_dev.
package timer_dev_pkg;

   localparam int unsigned DATA_W = 32;
   localparam int unsigned OFF_W  = 4;

   // Byte offsets within the 16-byte window
   localparam logic [OFF_W-1:0] TIMER_CTRL   = 4'h0;
   localparam logic [OFF_W-1:0] TIMER_PRESET = 4'h4;
   localparam logic [OFF_W-1:0] TIMER_COUNT  = 4'h8;
   localparam logic [OFF_W-1:0] TIMER_RSVD   = 4'hC;

   // Word selects derived from the byte offsets
   localparam logic [1:0] SEL_CTRL   = TIMER_CTRL[3:2];
   localparam logic [1:0] SEL_PRESET = TIMER_PRESET[3:2];
   localparam logic [1:0] SEL_COUNT  = TIMER_COUNT[3:2];
   localparam logic [1:0] SEL_RSVD   = TIMER_RSVD[3:2];

   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_AUTO    = 2'b01;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_LOAD = 2'b01,
      ST_CNT  = 2'b10,
      ST_INT  = 2'b11
   } state_t;

   typedef struct packed {
      logic [27:0] rsvd;
      logic        im;
      logic [1:0]  mode;
      logic        en;
   } ctrl_t;

endpackage

// File: rtl/timer_dev.sv
// Memory-mapped countdown timer with CTRL/PRESET/COUNT registers and a masked interrupt.
// Auto-reload mode exists only when TIMER_AUTORELOAD_EN is defined; otherwise every count is one-shot.
module timer_dev
   import timer_dev_pkg::*;
#(
   parameter logic [DATA_W-1:0] BASE_ADDR = 32'h0000_7F00
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] addr,
   input  logic              we,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              irq
);

   logic              in_win;
   logic [1:0]        sel;
   logic              wr_ctrl;
   logic              wr_preset;
   logic              addr_unused;

   logic              en, en_n;
   logic              im, im_n;
   logic [1:0]        mode;
   logic              auto_mode;
   logic [DATA_W-1:0] preset, preset_n;
   logic [DATA_W-1:0] count, count_n;
   logic              pend, pend_n;
   logic              irq_n;
   logic              en_clr;
   state_t            state, state_n;
   ctrl_t             ctrl_rd;

   // Bus decode; byte lane bits are ignored
   assign in_win      = (addr[DATA_W-1:4] == BASE_ADDR[DATA_W-1:4]);
   assign sel         = addr[3:2];
   assign wr_ctrl     = we & in_win & (sel == SEL_CTRL);
   assign wr_preset   = we & in_win & (sel == SEL_PRESET);
   assign addr_unused = ^addr[1:0];

`ifdef TIMER_AUTORELOAD_EN
   logic [1:0] mode_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset)        mode_q <= MODE_ONESHOT;
      else if (wr_ctrl) mode_q <= wdata[2:1];
   end

   assign mode = mode_q;
`else
   assign mode = MODE_ONESHOT;
`endif

   assign auto_mode = (mode == MODE_AUTO);

   // FSM state register and datapath registers
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state  <= ST_IDLE;
         en     <= 1'b0;
         im     <= 1'b0;
         preset <= '0;
         count  <= '0;
         pend   <= 1'b0;
         irq    <= 1'b0;
      end else begin
         state  <= state_n;
         en     <= en_n;
         im     <= im_n;
         preset <= preset_n;
         count  <= count_n;
         pend   <= pend_n;
         irq    <= irq_n;
      end
   end

   // Next-state and COUNT update; FSM acts on the registered EN
   always_comb begin
      state_n = state;
      count_n = count;
      en_clr  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (en) state_n = ST_LOAD;
         end
         ST_LOAD: begin
            if (!en) begin
               state_n = ST_IDLE;
            end else begin
               count_n = preset;
               state_n = ST_CNT;
            end
         end
         ST_CNT: begin
            if (!en) begin
               state_n = ST_IDLE;
            end else if (count <= DATA_W'(1)) begin
               count_n = '0;
               state_n = ST_INT;
            end else begin
               count_n = count - DATA_W'(1);
            end
         end
         ST_INT: begin
            if (auto_mode && en) begin
               state_n = ST_LOAD;
            end else begin
               state_n = ST_IDLE;
               en_clr  = ~auto_mode;
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   // Register writes, pending flag and interrupt; a CTRL write overrides the FSM's EN clear
   always_comb begin
      en_n     = wr_ctrl   ? wdata[0] : (en & ~en_clr);
      im_n     = wr_ctrl   ? wdata[3] : im;
      preset_n = wr_preset ? wdata    : preset;
      pend_n   = pend;
      if (state_n == ST_INT)         pend_n = 1'b1;
      else if (auto_mode)            pend_n = 1'b0;
      else if (wr_ctrl || wr_preset) pend_n = 1'b0;
      irq_n = im_n & pend_n;
   end

   // Combinational read mux
   always_comb begin
      rdata        = '0;
      ctrl_rd      = '0;
      ctrl_rd.en   = en;
      ctrl_rd.mode = mode;
      ctrl_rd.im   = im;
      if (in_win) begin
         case (sel)
            SEL_CTRL:   rdata = ctrl_rd;
            SEL_PRESET: rdata = preset;
            SEL_COUNT:  rdata = count;
            SEL_RSVD:   rdata = '0;
            default:    rdata = '0;
         endcase
      end
   end

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: directed scenarios plus randomized runs against a closed-form model.
module tb_timer_dev;

   localparam logic [31:0] BASE = 32'h0000_7F00;
   localparam logic [31:0] A_CTRL   = BASE + 32'h0;
   localparam logic [31:0] A_PRESET = BASE + 32'h4;
   localparam logic [31:0] A_COUNT  = BASE + 32'h8;
   localparam logic [31:0] A_RSVD   = BASE + 32'hC;

   logic        clk;
   logic        reset;
   logic [31:0] addr;
   logic        we;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        irq;

   int unsigned checks;
   int unsigned errors;

   timer_dev #(.BASE_ADDR(BASE)) dut (
      .clk   (clk),
      .reset (reset),
      .addr  (addr),
      .we    (we),
      .wdata (wdata),
      .rdata (rdata),
      .irq   (irq)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h exp %h", tag, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Write sampled at the next rising edge; returns just after that edge
   task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
      @(negedge clk);
      addr  = a;
      wdata = d;
      we    = 1'b1;
      @(posedge clk);
      #1;
      we    = 1'b0;
   endtask

   task automatic rd(input logic [31:0] a, output logic [31:0] d);
      we   = 1'b0;
      addr = a;
      #1;
      d = rdata;
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
   endtask

   // Edge index (relative to the enabling CTRL write) at which the timer first signals
   function automatic int t_int(input int p);
      return ((p == 0) ? 1 : p) + 2;
   endfunction

   function automatic logic [31:0] exp_count(input int p, input bit auto, input int k);
      int t, j;
      t = t_int(p);
      if (k < 2) return 32'd0;
      if (k < t) return 32'(p - (k - 2));
      if (!auto) return 32'd0;
      j = (k - t) % t;
      if (j < 2) return 32'd0;
      return 32'(p - (j - 2));
   endfunction

   function automatic bit exp_irq(input int p, input bit auto, input bit im, input int k);
      int t;
      t = t_int(p);
      if (!im || k < t) return 1'b0;
      if (auto) return ((k - t) % t) == 0;
      return 1'b1;
   endfunction

   function automatic logic [1:0] stored_mode(input logic [1:0] m);
`ifdef TIMER_AUTORELOAD_EN
      return m;
`else
      return 2'b00;
`endif
   endfunction

   initial begin
      logic [31:0] d;
      checks = 0;
      errors = 0;
      reset  = 1'b1;
      addr   = '0;
      we     = 1'b0;
      wdata  = '0;
      step(2);
      @(negedge clk);
      reset = 1'b0;

      // Reset values
      rd(A_CTRL, d);   check("rst_ctrl", d, 32'h0);
      rd(A_PRESET, d); check("rst_preset", d, 32'h0);
      rd(A_COUNT, d);  check("rst_count", d, 32'h0);
      rd(A_RSVD, d);   check("rst_rsvd", d, 32'h0);
      check("rst_irq", 32'(irq), 32'h0);

      // Reset mid-count, asynchronous to clk
      bus_write(A_PRESET, 32'd10);
      bus_write(A_CTRL, 32'h9);
      step(5);
      rd(A_COUNT, d);  check("mid_count_before", d, 32'd7);
      #1;
      reset = 1'b1;
      rd(A_CTRL, d);   check("arst_ctrl", d, 32'h0);
      rd(A_PRESET, d); check("arst_preset", d, 32'h0);
      rd(A_COUNT, d);  check("arst_count", d, 32'h0);
      check("arst_irq", 32'(irq), 32'h0);
      @(negedge clk);
      reset = 1'b0;
      step(15);
      rd(A_COUNT, d);  check("arst_no_resume", d, 32'h0);
      check("arst_irq_after", 32'(irq), 32'h0);

      // One-shot: irq rises 7 edges after the CTRL write and stays
      do_reset();
      bus_write(A_PRESET, 32'd5);
      bus_write(A_CTRL, 32'h9);
      for (int k = 1; k <= 10; k++) begin
         step(1);
         check($sformatf("os_irq_k%0d", k), 32'(irq), 32'((k >= 7) ? 1 : 0));
      end
      rd(A_CTRL, d);  check("os_ctrl", d, 32'h8);
      rd(A_COUNT, d); check("os_count", d, 32'h0);
      bus_write(A_CTRL, 32'h8);
      check("os_irq_cleared", 32'(irq), 32'h0);
      step(2);
      check("os_irq_stays_clear", 32'(irq), 32'h0);

      // Auto-reload request (one-shot sticky when the feature is absent)
      do_reset();
      bus_write(A_PRESET, 32'd3);
      bus_write(A_CTRL, 32'hB);
      for (int k = 1; k <= 25; k++) begin
         step(1);
`ifdef TIMER_AUTORELOAD_EN
         check($sformatf("ar_irq_k%0d", k), 32'(irq), 32'((k >= 5 && (k - 5) % 5 == 0) ? 1 : 0));
`else
         check($sformatf("ar_irq_k%0d", k), 32'(irq), 32'((k >= 5) ? 1 : 0));
`endif
      end
`ifdef TIMER_AUTORELOAD_EN
      rd(A_CTRL, d); check("ar_ctrl", d, 32'hB);
`else
      rd(A_CTRL, d); check("ar_ctrl", d, 32'h8);
`endif

      // Masked interrupt, then unmask: the CTRL write clears PEND
      do_reset();
      bus_write(A_PRESET, 32'd2);
      bus_write(A_CTRL, 32'h1);
      for (int k = 1; k <= 6; k++) begin
         step(1);
         check($sformatf("mask_irq_k%0d", k), 32'(irq), 32'h0);
      end
      rd(A_COUNT, d); check("mask_count", d, 32'h0);
      bus_write(A_CTRL, 32'h8);
      check("mask_unmask_irq", 32'(irq), 32'h0);
      step(3);
      check("mask_unmask_irq_later", 32'(irq), 32'h0);

      // Stop after 20 edges: COUNT freezes at 82 and the FSM idles
      do_reset();
      bus_write(A_PRESET, 32'd100);
      bus_write(A_CTRL, 32'h9);
      step(19);
      bus_write(A_CTRL, 32'h8);
      step(3);
      rd(A_COUNT, d); check("stop_count", d, 32'd82);
      step(5);
      rd(A_COUNT, d); check("stop_count_held", d, 32'd82);
      bus_write(A_CTRL, 32'h9);
      step(2);
      rd(A_COUNT, d); check("stop_reload", d, 32'd100);

      // Out-of-window and read-only writes
      do_reset();
      bus_write(A_PRESET, 32'h1234);
      bus_write(A_CTRL, 32'h8);
      bus_write(A_RSVD, 32'hFFFF_FFFF);
      bus_write(BASE + 32'h10, 32'hFFFF_FFFF);
      bus_write(A_COUNT, 32'd7);
      bus_write(BASE - 32'h4, 32'hFFFF_FFFF);
      rd(A_CTRL, d);          check("oow_ctrl", d, 32'h8);
      rd(A_PRESET, d);        check("oow_preset", d, 32'h1234);
      rd(A_COUNT, d);         check("oow_count", d, 32'h0);
      rd(A_RSVD, d);          check("oow_rsvd", d, 32'h0);
      rd(BASE + 32'h10, d);   check("oow_above", d, 32'h0);
      rd(BASE + 32'h5, d);    check("byte_lane_ignored", d, 32'h1234);

      // Randomized runs against the closed-form model
      for (int it = 0; it < 8; it++) begin
         int          p, t;
         logic [1:0]  wm, sm;
         bit          im, auto;
         logic [31:0] ctrl_w, ctrl_e;
         p  = int'($urandom_range(0, 9));
         wm = 2'($urandom_range(0, 3));
         im = 1'($urandom_range(0, 1));
         sm = stored_mode(wm);
         auto = (sm == 2'b01);
         t  = t_int(p);
         ctrl_w = {28'd0, im, wm, 1'b1};
         do_reset();
         bus_write(A_PRESET, 32'(p));
         bus_write(A_CTRL, ctrl_w);
         for (int k = 0; k <= 3 * t + 2; k++) begin
            ctrl_e = {28'd0, im, sm, 1'b1};
            if (!auto && k >= t + 1) ctrl_e[0] = 1'b0;
            rd(A_COUNT, d);
            check($sformatf("rnd%0d_count_k%0d", it, k), d, exp_count(p, auto, k));
            rd(A_CTRL, d);
            check($sformatf("rnd%0d_ctrl_k%0d", it, k), d, ctrl_e);
            check($sformatf("rnd%0d_irq_k%0d", it, k), 32'(irq), 32'(exp_irq(p, auto, im, k)));
            step(1);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
